// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder pin and position bus bundle for quad_decoder
interface quad_decoder_if #(
  parameter int N = 16
);
  logic         a;
  logic         b;
  logic         idx;
  logic         en;
  logic         clr;
  logic         idx_en;
  logic         err_clr;
  logic [N-1:0] pos;
  logic         dir;
  logic         step;
  logic         err;

  // Driver side: pins and controls out, position status in
  modport master (
    output a, b, idx, en, clr, idx_en, err_clr,
    input  pos, dir, step, err
  );

  // Decoder side
  modport slave (
    input  a, b, idx, en, clr, idx_en, err_clr,
    output pos, dir, step, err
  );
endinterface

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - x4 quadrature decoder with sync, glitch filter and index zeroing
module quad_decoder #(
  parameter int N    = 16,
  parameter int FILT = 3
) (
  input logic            clk,
  input logic            rst_n,
  quad_decoder_if.slave  bus
);

  // Channel bit order inside the packed vectors: [2]=idx, [1]=a, [0]=b
  localparam logic [3:0] FILT_M1 = 4'(FILT - 1);

  logic [2:0]   sync1_q, sync2_q;
  logic [2:0]   filt_q, filt_d;
  logic [3:0]   cnt_q [3];
  logic [3:0]   cnt_d [3];
  logic [1:0]   prev_q;
  logic         idx_prev_q;
  logic [N-1:0] pos_q, pos_d;
  logic         dir_q, dir_d;
  logic         step_q, step_d;
  logic         err_q, err_d;

  logic [1:0] ab;
  logic [1:0] delta;
  logic       legal;
  logic       illegal;
  logic       up;
  logic       idx_rise;

  // Per-channel filter: count consecutive mismatching cycles, accept new level on the FILT-th
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = 4'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FILT_M1) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Gray-code step decode against the previous filtered {a,b}
  always_comb begin
    ab       = filt_q[1:0];
    delta    = ab ^ prev_q;
    legal    = ^delta;
    illegal  = &delta;
    // Forward order 00->01->11->10 always satisfies prev[1] != cur[0]
    up       = prev_q[1] ^ ab[0];
    idx_rise = filt_q[2] & ~idx_prev_q & bus.idx_en & (ab == 2'b00);
  end

  // Next-state for position, direction, strobe and sticky error; clr beats index beats step
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = err_q;
    if (legal && bus.en) begin
      step_d = 1'b1;
      dir_d  = up;
      pos_d  = up ? pos_q + N'(1) : pos_q - N'(1);
    end
    if (idx_rise) pos_d = '0;
    if (bus.clr)  pos_d = '0;
    if (bus.err_clr) err_d = 1'b0;
    if (illegal)     err_d = 1'b1;
  end

  // State registers; prev_q tracks every cycle so a disabled counter resumes without a burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      prev_q     <= '0;
      idx_prev_q <= 1'b0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= {bus.idx, bus.a, bus.b};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      prev_q     <= filt_q[1:0];
      idx_prev_q <= filt_q[2];
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign bus.pos  = pos_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder
module tb_quad_decoder;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   step_cnt;
  int   base;
  int   first_k;
  int   ph;
  logic [1:0] up_seq [4];

  quad_decoder_if #(.N(16)) bus ();

  quad_decoder #(.N(16), .FILT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count step strobes, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n && bus.step === 1'b1) step_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ab(input logic [1:0] v, input int hold);
    bus.a = v[1];
    bus.b = v[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic step_up();
    ph = (ph + 1) % 4;
    drive_ab(up_seq[ph], 8);
  endtask

  task automatic step_dn();
    ph = (ph + 3) % 4;
    drive_ab(up_seq[ph], 8);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    step_cnt = 0;
    ph       = 0;
    up_seq[0] = 2'b00;
    up_seq[1] = 2'b01;
    up_seq[2] = 2'b11;
    up_seq[3] = 2'b10;
    rst_n       = 1'b0;
    bus.a       = 1'b0;
    bus.b       = 1'b0;
    bus.idx     = 1'b0;
    bus.en      = 1'b1;
    bus.clr     = 1'b0;
    bus.idx_en  = 1'b0;
    bus.err_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_pos",  32'(bus.pos), 32'h0);
    chk("reset_dir",  32'(bus.dir), 32'h0);
    chk("reset_step", 32'(bus.step), 32'h0);
    chk("reset_err",  32'(bus.err), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Forward: first transition with latency measurement, then 15 more
    step_cnt = 0;
    first_k  = 0;
    ph = 1;
    bus.a = 1'b0;
    bus.b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.step === 1'b1 && first_k == 0) first_k = k;
    end
    @(negedge clk);
    chk("latency_edges", 32'(first_k), 32'd6);
    for (int t = 0; t < 15; t++) step_up();
    chk("fwd_pos",   32'(bus.pos), 32'd16);
    chk("fwd_dir",   32'(bus.dir), 32'h1);
    chk("fwd_steps", 32'(step_cnt), 32'd16);
    chk("fwd_err",   32'(bus.err), 32'h0);

    // Wrap both ways
    pulse_clr();
    chk("clr_pos", 32'(bus.pos), 32'h0);
    step_dn();
    chk("wrap_dn_pos", 32'(bus.pos), 32'hFFFF);
    chk("wrap_dn_dir", 32'(bus.dir), 32'h0);
    step_up();
    chk("wrap_up_pos", 32'(bus.pos), 32'h0);
    chk("wrap_up_dir", 32'(bus.dir), 32'h1);

    // Glitch shorter than FILT is rejected; a held level gives one step
    base = step_cnt;
    bus.a = 1'b1;
    repeat (2) @(negedge clk);
    bus.a = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_steps", 32'(step_cnt - base), 32'd0);
    chk("glitch_pos",   32'(bus.pos), 32'h0);
    chk("glitch_err",   32'(bus.err), 32'h0);
    base = step_cnt;
    step_dn();
    chk("held_steps", 32'(step_cnt - base), 32'd1);
    chk("held_pos",   32'(bus.pos), 32'hFFFF);
    step_up();
    chk("held_back_pos", 32'(bus.pos), 32'h0);

    // Illegal double change 00->11
    base = step_cnt;
    ph = 2;
    drive_ab(2'b11, 8);
    chk("illegal_err",   32'(bus.err), 32'h1);
    chk("illegal_pos",   32'(bus.pos), 32'h0);
    chk("illegal_steps", 32'(step_cnt - base), 32'd0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(bus.err), 32'h0);

    // Index zeroing: reach pos=37 at ab=00
    step_up();
    pulse_clr();
    for (int t = 0; t < 37; t++) step_up();
    chk("pre_idx_pos", 32'(bus.pos), 32'd37);
    bus.idx_en = 1'b1;
    bus.idx = 1'b1;
    repeat (8) @(negedge clk);
    chk("idx_zero_pos", 32'(bus.pos), 32'h0);
    bus.idx = 1'b0;
    repeat (8) @(negedge clk);
    step_up();
    chk("pre_idx01_pos", 32'(bus.pos), 32'd1);
    bus.idx = 1'b1;
    repeat (8) @(negedge clk);
    chk("idx_ab01_pos", 32'(bus.pos), 32'd1);
    bus.idx = 1'b0;
    bus.idx_en = 1'b0;
    repeat (8) @(negedge clk);

    // clr coinciding with a forward step: clr wins for pos, step still pulses
    ph = 2;
    bus.a = 1'b1;
    bus.b = 1'b1;
    repeat (5) @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_step_step", 32'(bus.step), 32'h1);
    chk("clr_step_pos",  32'(bus.pos), 32'h0);
    chk("clr_step_dir",  32'(bus.dir), 32'h1);
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (6) @(negedge clk);

    // Enable gating
    base = step_cnt;
    bus.en = 1'b0;
    for (int t = 0; t < 5; t++) step_up();
    chk("en0_pos",   32'(bus.pos), 32'h0);
    chk("en0_steps", 32'(step_cnt - base), 32'd0);
    bus.en = 1'b1;
    step_up();
    chk("en1_pos",   32'(bus.pos), 32'd1);
    chk("en1_steps", 32'(step_cnt - base), 32'd1);

    // Set err, then async reset between clock edges
    ph = (ph + 2) % 4;
    drive_ab(up_seq[ph], 8);
    chk("pre_rst_err", 32'(bus.err), 32'h1);
    chk("pre_rst_pos", 32'(bus.pos), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pos", 32'(bus.pos), 32'h0);
    chk("async_rst_err", 32'(bus.err), 32'h0);
    chk("async_rst_dir", 32'(bus.dir), 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_hold_pos", 32'(bus.pos), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Decodes a two-phase quadrature encoder (A/B plus optional index) into a signed-direction position count.
- Sits between external encoder pins and the datapath.
- Synchronises the asynchronous inputs, glitch-filters them, and decodes x4 transitions into a wrapping up/down position register.
- Also produces a per-step strobe, the last direction, and a sticky illegal-transition error flag.

Parameters:
- N, 16, position counter width in bits.
- FILT, 3, consecutive stable cycles required before a filtered input accepts a new level; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a  in  1  encoder phase A, asynchronous.
- b  in  1  encoder phase B, asynchronous.
- idx  in  1  encoder index, asynchronous.
- en  in  1  count enable.
- clr  in  1  synchronous position clear.
- idx_en  in  1  enables index-zeroing of the position.
- err_clr  in  1  clears the sticky error flag.
- pos  out  N  current position, modulo 2^N.
- dir  out  1  direction of the last counted step; 1 = up, 0 = down.
- step  out  1  one-cycle strobe on each counted step.
- err  out  1  sticky flag set by an illegal transition.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following clear immediately and hold while rst_n is low:
  - pos=0, dir=0, step=0, err=0.
  - Synchroniser flops=0, filter counters=0.
  - Filtered a/b/idx=0; previous-state register=00.
- Reset release: the first edge with rst_n high performs normal operation.
- Synchronisation: a, b and idx each pass through two flops.
- Filter, one per channel:
  - A counter increments while the synced value differs from the filtered value.
  - The counter resets to 0 on any cycle where they match.
  - When the counter reaches FILT, the filtered value takes the synced value and the counter returns to 0.
- Latency: a clean level change on a pin, held steady, updates pos/step exactly FILT+3 rising edges after the first edge that samples it.
- Decode compares the current filtered state {a,b} against the previous state register, which updates every cycle.
  - Up (forward) sequence: 00->01->11->10->00.
  - Down sequence: 00->10->11->01->00.
  - No change: nothing happens.
  - Both bits change in one cycle (00<->11 or 01<->10): illegal. err=1, pos unchanged, step=0, dir unchanged.
- Counting on a legal step with en=1:
  - pos +1 (up) or -1 (down), wrapping: 2^N-1 +1 -> 0, 0 -1 -> 2^N-1.
  - dir updated; step=1 for that cycle only.
- en=0:
  - The previous-state register still tracks, so no burst occurs when en rises.
  - pos/dir unchanged, step=0.
  - err detection remains active.
- Index zeroing: a rising edge of filtered idx while idx_en=1 and filtered {a,b}=00 sets pos=0.
  - An index edge in any other state is ignored.
- Priority for pos, in the same cycle: clr > index zero > step.
  - step still pulses and dir still updates when a legal step coincides with clr or index zero.
- err is sticky until an err_clr cycle.
  - If err_clr coincides with a new illegal transition, err stays 1 (set wins).
- pos, dir, step and err are all registered outputs.

Test Plan:
- Reset, FILT=3: drive 4 full forward cycles (16 transitions), each phase held 8 clocks -> pos=16, dir=1, 16 single-cycle step pulses, err=0. The first step appears 6 edges after the first change is sampled.
- Wrap: from pos=0 (after clr), drive 1 reverse transition 00->10 -> pos=16'hFFFF, dir=0. Then 1 forward transition 10->00 -> pos=0, dir=1.
- Glitch: pulse a high for 2 clocks (less than FILT) with b=0 -> no step, pos unchanged, err=0. Hold it 3+ clocks -> exactly one step.
- Illegal: drive a and b from 00 to 11 on the same cycle -> err=1, pos unchanged, step never asserted. Assert err_clr for 1 cycle -> err=0.
- Index and priority: pos=37, idx_en=1, ab=00, raise idx -> pos=0. Repeat with ab=01 -> pos unchanged. Assert clr on the same cycle as a forward step -> pos=0, step=1.
- Enable and async reset: en=0 during 5 forward transitions -> pos unchanged. Set en=1 and apply 1 more transition -> pos +1 only. Pull rst_n low mid-sequence, between clock edges -> pos=0, err=0 immediately.
